// File: rtl/motor_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// motor_ctrl_pkg : shared duty width, speed levels and ramp state encoding
// Rev 1.0 : initial release
// ============================================================================
package motor_ctrl_pkg;

   localparam int DUTY_W     = 7;
   localparam int DUTY_MAX   = 100;
   localparam int LEVEL1_DEF = 35;
   localparam int LEVEL2_DEF = 70;
   localparam int LEVEL3_DEF = 100;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      HOLD      = 2'd1,
      RAMP_UP   = 2'd2,
      RAMP_DOWN = 2'd3
   } ramp_state_t;

   // Out-of-range levels saturate so the duty command can never exceed full scale
   function automatic logic [DUTY_W-1:0] level_clamp(input int level);
      return (level > DUTY_MAX) ? DUTY_W'(DUTY_MAX) : DUTY_W'(level);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ramp_tick_gen.sv
`default_nettype none
// ============================================================================
// ramp_tick_gen : step-rate counter, one-cycle tick every PERIOD_CYC enabled cycles
// Rev 1.0 : initial release
// ============================================================================
module ramp_tick_gen #(
   parameter int unsigned PERIOD_CYC = 4
) (
   input  logic clk,
   input  logic reset_p,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_tick
);

   localparam int unsigned        c_cnt_w = (PERIOD_CYC > 2) ? $clog2(PERIOD_CYC) : 1;
   localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(PERIOD_CYC - 1);

   logic [c_cnt_w-1:0] r_cnt;

   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p)
         r_cnt <= '0;
      else if (i_clear || !i_enable || (r_cnt == c_last))
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + c_cnt_w'(1);
   end

   // A clear restarts the full period, so a tick never lands on the clearing edge
   assign o_tick = i_enable && !i_clear && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/motor_duty_ramp.sv
`default_nettype none
// ============================================================================
// motor_duty_ramp : button-driven speed mode with slew-limited PWM duty command
// Optional idle auto-off: define MOTOR_DUTY_RAMP_AUTO_OFF_EN
// Rev 1.0 : initial release
// ============================================================================
module motor_duty_ramp
   import motor_ctrl_pkg::*;
#(
   parameter int unsigned RAMP_STEP_CYC    = 1_250_000,
   parameter int          LEVEL1           = LEVEL1_DEF,
   parameter int          LEVEL2           = LEVEL2_DEF,
   parameter int          LEVEL3           = LEVEL3_DEF,
   parameter logic [32:0] IDLE_TIMEOUT_CYC = 33'd7_500_000_000
) (
   input  logic              clk,
   input  logic              reset_p,
   input  logic              btn_mode_ne,
   input  logic              btn_stop_ne,
   output logic [DUTY_W-1:0] duty,
   output logic [1:0]        mode,
   output logic              ramping,
   output logic              at_target
);

   localparam logic [DUTY_W-1:0] c_level1 = level_clamp(LEVEL1);
   localparam logic [DUTY_W-1:0] c_level2 = level_clamp(LEVEL2);
   localparam logic [DUTY_W-1:0] c_level3 = level_clamp(LEVEL3);

   logic [1:0]        r_mode;
   logic [DUTY_W-1:0] r_duty;
   logic [DUTY_W-1:0] w_target;
   ramp_state_t       r_state;
   ramp_state_t       w_state_next;
   logic              r_ramping;
   logic              r_at_target;
   logic              w_ramping_next;
   logic              w_auto_off;
   logic              w_mode_change;
   logic              w_tick;

   always_comb begin
      w_target = '0;
      case (r_mode)
         2'd1:    w_target = c_level1;
         2'd2:    w_target = c_level2;
         2'd3:    w_target = c_level3;
         default: w_target = '0;
      endcase
   end

   assign w_mode_change = btn_mode_ne | btn_stop_ne | w_auto_off;

   ramp_tick_gen #(
      .PERIOD_CYC (RAMP_STEP_CYC)
   ) u_tick (
      .clk      (clk),
      .reset_p  (reset_p),
      .i_clear  (w_mode_change),
      .i_enable (r_duty != w_target),
      .o_tick   (w_tick)
   );

`ifdef MOTOR_DUTY_RAMP_AUTO_OFF_EN
   localparam logic [32:0] c_idle_last = IDLE_TIMEOUT_CYC - 33'd1;

   logic [32:0] r_idle_cnt;

   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p)
         r_idle_cnt <= '0;
      else if (btn_mode_ne || btn_stop_ne || (r_mode == 2'd0) || w_auto_off)
         r_idle_cnt <= '0;
      else
         r_idle_cnt <= r_idle_cnt + 33'd1;
   end

   assign w_auto_off = (r_mode != 2'd0) && (r_idle_cnt == c_idle_last)
                       && !btn_mode_ne && !btn_stop_ne;
`else
   logic w_unused_timeout;
   assign w_unused_timeout = ^IDLE_TIMEOUT_CYC;
   assign w_auto_off       = 1'b0;
`endif

   // Stop outranks a simultaneous mode pulse
   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p)
         r_mode <= 2'd0;
      else if (btn_stop_ne || w_auto_off)
         r_mode <= 2'd0;
      else if (btn_mode_ne)
         r_mode <= r_mode + 2'd1;
   end

   // Direction comes from the registered state; the tick is always at least one
   // cycle behind any target change, so the state has already caught up
   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p)
         r_duty <= '0;
      else if (btn_stop_ne)
         r_duty <= '0;
      else if (w_tick) begin
         if ((r_state == RAMP_UP) && (r_duty < w_target))
            r_duty <= r_duty + DUTY_W'(1);
         else if ((r_state == RAMP_DOWN) && (r_duty > w_target))
            r_duty <= r_duty - DUTY_W'(1);
      end
   end

   always_comb begin
      w_state_next   = IDLE;
      w_ramping_next = 1'b0;
      if (r_duty < w_target) begin
         w_state_next   = RAMP_UP;
         w_ramping_next = 1'b1;
      end else if (r_duty > w_target) begin
         w_state_next   = RAMP_DOWN;
         w_ramping_next = 1'b1;
      end else if (r_duty != '0) begin
         w_state_next   = HOLD;
      end
   end

   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         r_state     <= IDLE;
         r_ramping   <= 1'b0;
         r_at_target <= 1'b1;
      end else begin
         r_state     <= w_state_next;
         r_ramping   <= w_ramping_next;
         r_at_target <= !w_ramping_next;
      end
   end

   assign duty      = r_duty;
   assign mode      = r_mode;
   assign ramping   = r_ramping;
   assign at_target = r_at_target;

endmodule
`default_nettype wire

// File: tb/tb_motor_duty_ramp.sv
`default_nettype none
// ============================================================================
// tb_motor_duty_ramp : directed vector bench for motor_duty_ramp (step = 4 cycles)
// Rev 1.0 : initial release
// ============================================================================
module tb_motor_duty_ramp;

   logic       clk;
   logic       reset_p;
   logic       btn_mode_ne;
   logic       btn_stop_ne;
   logic [6:0] duty;
   logic [1:0] mode;
   logic       ramping;
   logic       at_target;

   int n_tests;
   int n_fail;

   typedef struct {
      bit bm;
      bit bs;
      int wait_n;
      int e_duty;
      int e_mode;
      bit e_ramp;
      bit e_at;
   } vec_t;

   vec_t vecs[22];

   motor_duty_ramp #(
      .RAMP_STEP_CYC    (4),
      .IDLE_TIMEOUT_CYC (33'd50)
   ) dut (
      .clk         (clk),
      .reset_p     (reset_p),
      .btn_mode_ne (btn_mode_ne),
      .btn_stop_ne (btn_stop_ne),
      .duty        (duty),
      .mode        (mode),
      .ramping     (ramping),
      .at_target   (at_target)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input int d, input int m, input bit r, input bit a);
      check({tag, ".duty"},      int'(duty),      d);
      check({tag, ".mode"},      int'(mode),      m);
      check({tag, ".ramping"},   int'(ramping),   int'(r));
      check({tag, ".at_target"}, int'(at_target), int'(a));
   endtask

   // Called at a falling edge; the buttons are seen by exactly the next rising edge
   task automatic pulse(input bit bm, input bit bs);
      btn_mode_ne = bm;
      btn_stop_ne = bs;
      @(negedge clk);
      btn_mode_ne = 1'b0;
      btn_stop_ne = 1'b0;
   endtask

   task automatic wait_edges(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;

      // {mode, stop, extra edges, duty, mode, ramping, at_target}
      vecs[0]  = '{1'b0, 1'b0,   0,   0, 0, 1'b0, 1'b1};
      vecs[1]  = '{1'b1, 1'b0,   0,   0, 1, 1'b0, 1'b1};
      vecs[2]  = '{1'b0, 1'b0,   2,   0, 1, 1'b1, 1'b0};
      vecs[3]  = '{1'b0, 1'b0,   0,   1, 1, 1'b1, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 135,  35, 1, 1'b1, 1'b0};
      vecs[5]  = '{1'b0, 1'b0,   0,  35, 1, 1'b0, 1'b1};
      vecs[6]  = '{1'b0, 1'b0,  10,  35, 1, 1'b0, 1'b1};
      vecs[7]  = '{1'b1, 1'b0,   0,  35, 2, 1'b0, 1'b1};
      vecs[8]  = '{1'b0, 1'b0,  59,  50, 2, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, 1'b1,   0,   0, 0, 1'b1, 1'b0};
      vecs[10] = '{1'b0, 1'b0,   0,   0, 0, 1'b0, 1'b1};
      vecs[11] = '{1'b1, 1'b0,   0,   0, 1, 1'b0, 1'b1};
      vecs[12] = '{1'b1, 1'b1,   0,   0, 0, 1'b1, 1'b0};
      vecs[13] = '{1'b0, 1'b0,   5,   0, 0, 1'b0, 1'b1};
      vecs[14] = '{1'b1, 1'b0,   0,   0, 1, 1'b0, 1'b1};
      vecs[15] = '{1'b1, 1'b0,   0,   0, 2, 1'b1, 1'b0};
      vecs[16] = '{1'b1, 1'b0, 400, 100, 3, 1'b1, 1'b0};
      vecs[17] = '{1'b0, 1'b0,   0, 100, 3, 1'b0, 1'b1};
      vecs[18] = '{1'b1, 1'b0,   0, 100, 0, 1'b0, 1'b1};
      vecs[19] = '{1'b0, 1'b0,   3,  99, 0, 1'b1, 1'b0};
      vecs[20] = '{1'b0, 1'b0, 395,   0, 0, 1'b1, 1'b0};
      vecs[21] = '{1'b0, 1'b0,   0,   0, 0, 1'b0, 1'b1};

      reset_p     = 1'b1;
      btn_mode_ne = 1'b0;
      btn_stop_ne = 1'b0;
      wait_edges(3);
      check_outs("reset", 0, 0, 1'b0, 1'b1);
      reset_p = 1'b0;

`ifndef MOTOR_DUTY_RAMP_AUTO_OFF_EN
      for (int i = 0; i < 22; i++) begin
         pulse(vecs[i].bm, vecs[i].bs);
         wait_edges(vecs[i].wait_n);
         check_outs($sformatf("v%0d", i), vecs[i].e_duty, vecs[i].e_mode,
                    vecs[i].e_ramp, vecs[i].e_at);
      end

      // Asynchronous reset in the middle of an up-ramp
      pulse(1'b1, 1'b0);
      wait_edges(68);
      check_outs("pre_reset", 17, 1, 1'b1, 1'b0);
      #2 reset_p = 1'b1;
      #1 check_outs("async_reset", 0, 0, 1'b0, 1'b1);
      @(negedge clk);
      reset_p = 1'b0;
      wait_edges(6);
      check_outs("post_reset", 0, 0, 1'b0, 1'b1);

      // Without auto-off, mode 2 holds at 70 indefinitely
      pulse(1'b1, 1'b0);
      pulse(1'b1, 1'b0);
      wait_edges(279);
      check_outs("m2_k279", 69, 2, 1'b1, 1'b0);
      wait_edges(1);
      check_outs("m2_k280", 70, 2, 1'b1, 1'b0);
      wait_edges(20);
      check_outs("m2_hold", 70, 2, 1'b0, 1'b1);
      wait_edges(500);
      check_outs("m2_hold_long", 70, 2, 1'b0, 1'b1);
`else
      // Idle timeout counts from the last mode pulse, then ramps down normally
      pulse(1'b1, 1'b0);
      pulse(1'b1, 1'b0);
      wait_edges(49);
      check_outs("ao_k49", 12, 2, 1'b1, 1'b0);
      wait_edges(1);
      check_outs("ao_k50", 12, 0, 1'b1, 1'b0);
      wait_edges(4);
      check_outs("ao_k54", 11, 0, 1'b1, 1'b0);
      wait_edges(44);
      check_outs("ao_k98", 0, 0, 1'b1, 1'b0);
      wait_edges(1);
      check_outs("ao_idle", 0, 0, 1'b0, 1'b1);
      wait_edges(100);
      check_outs("ao_stays", 0, 0, 1'b0, 1'b1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
